genius_param: RTL
=================

GENIUS_PARAM -- requirements
Module: genius_param

Interface
REQ-001 The block SHALL be parametrised as follows, one parameter per line:
- NUM_BTNS, default 4: number of colour buttons/symbols, range 2..8.
- MAX_LEVEL, default 16: sequence length needed to win, range 1..32.
- SHOW_TICKS, default 4: cycles each symbol is displayed.
- GAP_TICKS, default 2: blank cycles after each displayed symbol.
- TIMEOUT_TICKS, default 1000: idle cycles allowed between presses; 0 disables the timeout.
- SYM_W = max(1, clog2(NUM_BTNS)) and LVL_W = clog2(MAX_LEVEL+1): derived widths.

REQ-002 The block SHALL have the following ports, one per line:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level-sensitive game start/restart request.
- seed  in  16  LFSR seed, sampled at game start.
- btn  in  NUM_BTNS  player buttons, one-hot when valid, synchronous to clock.
- show_valid  out  1  a sequence symbol is being displayed.
- show_symbol  out  SYM_W  symbol being displayed; 0 when show_valid=0.
- level  out  LVL_W  current sequence length.
- progress  out  MAX_LEVEL  bit i set once symbol i has been correctly entered this level.
- busy  out  1  high in every state except IDLE, WIN and LOSE.
- win  out  1  game won.
- lose  out  1  game lost.

Function
REQ-003 The FSM SHALL have the states IDLE, SHOW_ON, SHOW_GAP, WAIT_INPUT, LEVEL_UP, WIN and LOSE.
REQ-004 IDLE with start=1 SHALL:
- load the LFSR with seed, or 16'hACE1 if seed=0;
- write symbol 0 = lfsr[15:0] mod NUM_BTNS into an internal MAX_LEVEL x SYM_W memory;
- step the LFSR; set level=1; clear progress;
- go to SHOW_ON with index=0.
REQ-005 The LFSR SHALL be a 16-bit Fibonacci LFSR with feedback bit15^bit13^bit12^bit10, shifted left, and SHALL step only on symbol generation.
REQ-006 SHOW_ON SHALL hold show_valid=1 and show_symbol=mem[index] for exactly SHOW_TICKS cycles, then go to SHOW_GAP.
REQ-007 SHOW_GAP SHALL hold show_valid=0 for GAP_TICKS cycles; GAP_TICKS=0 SHALL skip the state.
REQ-008 After the gap, if index<level-1 the block SHALL increment index and return to SHOW_ON; otherwise it SHALL clear index and the timeout counter and go to WAIT_INPUT.
REQ-009 A press SHALL be defined as btn & ~btn_prev, where btn_prev is btn registered one cycle earlier.
REQ-010 A press is correct only if exactly one bit rises, that bit equals mem[index], and no other btn bit is high.
REQ-011 A correct press SHALL set progress[index], clear the timeout counter and increment index.
REQ-012 Any other nonzero press SHALL go to LOSE on the next cycle.
REQ-013 With TIMEOUT_TICKS>0, the timeout counter SHALL increment each WAIT_INPUT cycle with no press; reaching TIMEOUT_TICKS SHALL go to LOSE.
REQ-014 When index reaches level after a correct press, the block SHALL go to WIN if level==MAX_LEVEL, otherwise to LEVEL_UP.
REQ-015 LEVEL_UP SHALL last exactly one cycle and SHALL:
- append mem[level] = lfsr mod NUM_BTNS and step the LFSR;
- increment level, clear progress and index;
- go to SHOW_ON.
REQ-016 WIN SHALL hold win=1 and LOSE SHALL hold lose=1; each SHALL hold level and progress frozen.
REQ-017 start=1 in WIN or LOSE SHALL restart exactly as from IDLE; start SHALL be ignored in all other states.
REQ-018 Button presses SHALL be ignored outside WAIT_INPUT, but btn_prev SHALL still update every cycle.

Reset
REQ-019 reset=0 SHALL asynchronously force:
- state=IDLE, show_valid=0, show_symbol=0, level=0, progress=0;
- busy=0, win=0, lose=0;
- index=0, timers=0, btn_prev=0, LFSR=16'hACE1.
REQ-020 Memory contents SHALL be don't-care after reset and never read before being written.
REQ-021 Reset asserted mid-game SHALL abandon the game with no residual state.

Verification
Parameters for all scenarios: NUM_BTNS=4, MAX_LEVEL=3, SHOW_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=10.
REQ-022 Start with seed=16'h0001 -> show_valid high for exactly 2 cycles with show_symbol=1, then low for 1 cycle, then busy=1 in WAIT_INPUT.
REQ-023 Correct presses at every level -> level steps 1,2,3; progress reaches 3'b111; win=1 one cycle after the last press.
REQ-024 Wrong symbol, or two buttons rising together at level 2 -> lose=1 one cycle later, with level=2 and progress showing the bits earned before the error.
REQ-025 No press for 10 cycles in WAIT_INPUT -> lose=1; a press at cycle 9 -> no loss and the counter restarts.
REQ-026 Button held across the SHOW to WAIT_INPUT transition -> no press registered until it is released and pressed again.
REQ-027 Reset pulsed during SHOW_ON -> all outputs zero immediately, asynchronously; a new start behaves exactly as REQ-022.

Source files
------------

// File: rtl/genius_param.sv
// genius_param: parametrised "Genius"/Simon memory game. An LFSR extends a symbol
// sequence by one entry per level; the player echoes it back on one-hot buttons.
module genius_param #(
  parameter int unsigned NUM_BTNS      = 4,
  parameter int unsigned MAX_LEVEL     = 16,
  parameter int unsigned SHOW_TICKS    = 4,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 1000,
  parameter int unsigned SYM_W         = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1,
  parameter int unsigned LVL_W         = $clog2(MAX_LEVEL + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          seed,
  input  logic [NUM_BTNS-1:0]  btn,
  output logic                 show_valid,
  output logic [SYM_W-1:0]     show_symbol,
  output logic [LVL_W-1:0]     level,
  output logic [MAX_LEVEL-1:0] progress,
  output logic                 busy,
  output logic                 win,
  output logic                 lose
);

  localparam int unsigned AW        = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int unsigned TICK_MX   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TW        = (TICK_MX > 0) ? $clog2(TICK_MX + 1) : 1;
  localparam int unsigned TOW       = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE, SHOW_ON, SHOW_GAP, WAIT_INPUT, LEVEL_UP, WIN, LOSE
  } state_e;

  state_e               state_q, state_d;
  logic [LVL_W-1:0]     index_q, index_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [MAX_LEVEL-1:0] progress_q, progress_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [TOW-1:0]       to_q, to_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_BTNS-1:0]  btn_prev_q;
  logic                 show_valid_q, show_valid_d;
  logic [SYM_W-1:0]     show_symbol_q, show_symbol_d;
  logic                 busy_q, busy_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;

  logic [SYM_W-1:0]     mem_q [MAX_LEVEL];
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [SYM_W-1:0]     mem_wdata;

  logic                 seq_done;
  logic [15:0]          seed_eff;
  logic [NUM_BTNS-1:0]  press;
  logic [SYM_W-1:0]     cur_sym;
  logic [NUM_BTNS-1:0]  exp_btn;
  logic                 correct;
  logic [SYM_W-1:0]     disp_sym;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [SYM_W-1:0] to_sym(input logic [15:0] v);
    return SYM_W'(v % 16'(NUM_BTNS));
  endfunction

  assign seed_eff = (seed == 16'h0000) ? LFSR_INIT : seed;
  assign press    = btn & ~btn_prev_q;
  assign cur_sym  = mem_q[AW'(index_q)];
  assign exp_btn  = NUM_BTNS'(1) << cur_sym;
  assign correct  = (press == exp_btn) && (btn == exp_btn);

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    level_d    = level_q;
    progress_d = progress_q;
    tick_d     = tick_q;
    to_d       = to_q;
    lfsr_d     = lfsr_q;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    seq_done   = 1'b0;

    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          mem_we     = 1'b1;
          mem_waddr  = '0;
          mem_wdata  = to_sym(seed_eff);
          lfsr_d     = lfsr_step(seed_eff);
          level_d    = LVL_W'(1);
          progress_d = '0;
          index_d    = '0;
          tick_d     = '0;
          to_d       = '0;
          state_d    = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (tick_q == TW'(SHOW_TICKS - 1)) begin
          tick_d = '0;
          if (GAP_TICKS != 0) state_d = SHOW_GAP;
          else                seq_done = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      SHOW_GAP: begin
        if (tick_q == TW'(GAP_TICKS - 1)) begin
          tick_d   = '0;
          seq_done = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      WAIT_INPUT: begin
        if (press != '0) begin
          if (correct) begin
            progress_d[AW'(index_q)] = 1'b1;
            to_d    = '0;
            index_d = index_q + LVL_W'(1);
            if (index_d == level_q)
              state_d = (level_q == LVL_W'(MAX_LEVEL)) ? WIN : LEVEL_UP;
          end else begin
            state_d = LOSE;
          end
        end else if (TIMEOUT_TICKS != 0) begin
          to_d = to_q + TOW'(1);
          if (to_d == TOW'(TIMEOUT_TICKS)) state_d = LOSE;
        end
      end
      LEVEL_UP: begin
        mem_we     = 1'b1;
        mem_waddr  = AW'(level_q);
        mem_wdata  = to_sym(lfsr_q);
        lfsr_d     = lfsr_step(lfsr_q);
        level_d    = level_q + LVL_W'(1);
        progress_d = '0;
        index_d    = '0;
        tick_d     = '0;
        state_d    = SHOW_ON;
      end
      default: state_d = IDLE;
    endcase

    // End of one displayed symbol: show the next one or hand over to the player
    if (seq_done) begin
      if ((index_q + LVL_W'(1)) < level_q) begin
        index_d = index_q + LVL_W'(1);
        state_d = SHOW_ON;
      end else begin
        index_d = '0;
        to_d    = '0;
        state_d = WAIT_INPUT;
      end
    end
  end

  // Bypass the memory when the symbol being shown is written this same cycle
  assign disp_sym = (mem_we && (mem_waddr == AW'(index_d))) ? mem_wdata : mem_q[AW'(index_d)];

  always_comb begin
    show_valid_d  = (state_d == SHOW_ON);
    show_symbol_d = (state_d == SHOW_ON) ? disp_sym : '0;
    busy_d        = !((state_d == IDLE) || (state_d == WIN) || (state_d == LOSE));
    win_d         = (state_d == WIN);
    lose_d        = (state_d == LOSE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      level_q       <= '0;
      progress_q    <= '0;
      tick_q        <= '0;
      to_q          <= '0;
      lfsr_q        <= LFSR_INIT;
      btn_prev_q    <= '0;
      show_valid_q  <= 1'b0;
      show_symbol_q <= '0;
      busy_q        <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      level_q       <= level_d;
      progress_q    <= progress_d;
      tick_q        <= tick_d;
      to_q          <= to_d;
      lfsr_q        <= lfsr_d;
      btn_prev_q    <= btn;
      show_valid_q  <= show_valid_d;
      show_symbol_q <= show_symbol_d;
      busy_q        <= busy_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end

  // Sequence storage needs no reset: every entry is written before it is read
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign show_valid  = show_valid_q;
  assign show_symbol = show_symbol_q;
  assign level       = level_q;
  assign progress    = progress_q;
  assign busy        = busy_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule
